// File: rtl/load_store_unit.sv
// Load/store master for a word-addressed data memory: one RV32I load/store at a time, sub-word loads extended, sub-word stores by read-modify-write.
// Latency from accept edge to resp_valid: rejected access 1 cycle, load/SW 2 cycles, SB/SH 3 cycles.
// req_ready is high only in IDLE. The response is a one-cycle pulse with no backpressure.
module load_store_unit #(
  parameter int MEM_WORDS   = 64,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [30:0] MemWordsL = 31'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, RMW, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        f3_bad, misalign, out_of_range, req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Classify the incoming request: illegal funct3, misalignment, or word index beyond memory.
  always_comb begin
    f3_bad       = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                          : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = CHECK_RANGE && ({1'b0, req_addr[31:2]} >= MemWordsL);
    req_err      = f3_bad || misalign || out_of_range;
  end

  // Pick the addressed lane out of the read word and extend it according to funct3.
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    load_val = mem_RD;
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_RD[7:0];
      2'd1:    ld_byte = mem_RD[15:8];
      2'd2:    ld_byte = mem_RD[23:16];
      default: ld_byte = mem_RD[31:24];
    endcase
    case (f3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'h000000, ld_byte};
      3'b101:  load_val = {16'h0000, ld_half};
      default: load_val = mem_RD;
    endcase
  end

  // Overlay the store byte (SB) or half (SH) onto the current memory word.
  always_comb begin
    merged = mem_RD;
    if (!f3_q[0]) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state and next-register logic; the address register only moves on accepted
  // legal requests so mem_A keeps showing the last real memory address.
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          wdata_d = req_wdata[15:0];
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RESP;
          end else begin
            addr_d = req_addr;
            if (!req_we) begin
              state_d = LOAD;
            end else if (req_funct3 == 3'b010) begin
              wd_d    = req_wdata;
              state_d = WRITE;
            end else begin
              state_d = RMW;
            end
          end
        end
      end
      LOAD: begin
        rdata_d = load_val;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RMW: begin
        wd_d    = merged;
        state_d = WRITE;
      end
      WRITE: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation so mem_WE falls immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latched request, write data and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 16'h0;
      wd_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_WE     = (state_q == WRITE);
  assign mem_A      = {addr_q[31:2], 2'b00};
  assign mem_WD     = wd_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_WE;
  logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;

  load_store_unit #(.MEM_WORDS(64), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  // Data memory: synchronous write, combinational read
  logic [31:0] mem [64];
  assign mem_RD = mem[mem_A[7:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_WD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [31:0] ref_mem [64];

  int n_chk = 0, n_fail = 0;
  int resp_cnt = 0, we_cnt = 0;
  bit chk_en = 1'b1;
  logic [31:0] last_rdata, last_wa;
  logic        last_err;
  int          last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference behaviour: a request is applied to the reference memory when accepted
  task automatic apply_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int acc);
    exp_t e;
    wr_t w;
    logic [31:0] idx, v, mask, nw;
    int off, sz;
    bit legal, err;
    idx = a >> 2;
    off = int'(a % 4);
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0) || (idx >= 64);
    e.acc = acc; e.err = err; e.rdata = 32'h0; e.lat = 1;
    if (!err && !we) begin
      v = ref_mem[idx[5:0]] >> (8 * off);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v >= 128) v = v - 32'd256;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v >= 32768) v = v - 32'd65536;
      end
      e.rdata = v;
      e.lat = 2;
    end else if (!err) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 1) << (8 * off));
      nw = (ref_mem[idx[5:0]] & ~mask) | ((wd << (8 * off)) & mask);
      ref_mem[idx[5:0]] = nw;
      w.a = idx << 2; w.d = nw;
      wr_q.push_back(w);
      e.lat = (sz == 4) ? 2 : 3;
    end
    exp_q.push_back(e);
  endtask

  // Present a request from a falling edge until accepted; returns just after the accept edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit model);
    int waitc = 0;
    int acc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      fail_now("accept timeout");
    end else begin
      acc = cyc + 1;
      @(posedge clk);
      if (model) apply_model(we, f3, a, wd, acc);
    end
  endtask

  // Single request, then wait for its response
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int start, t;
    start = resp_cnt;
    t = 0;
    issue(we, f3, a, wd, 1'b1);
    #1 req_valid = 1'b0;
    while (resp_cnt == start && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (resp_cnt == start) fail_now("response timeout");
  endtask

  // Compare process: every response and every memory write against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected resp_valid");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          last_rdata = resp_rdata;
          last_err   = resp_err;
          last_lat   = cyc - e.acc + 1;
        end
        resp_cnt++;
      end
      if (mem_WE) begin
        we_cnt++;
        last_wa = mem_A;
        if (wr_q.size() == 0) begin
          fail_now("unexpected mem_WE");
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("mem_A on write", mem_A, w.a);
          chk("mem_WD on write", mem_WD, w.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] idx, off, a;
    int w0;
    int t;
    bit to;
    logic [2:0] ld_ok [5];
    ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_err", {31'b0, resp_err}, 32'd0);
    chk("reset mem_WE", {31'b0, mem_WE}, 32'd0);
    chk("reset mem_A", mem_A, 32'h0);
    chk("reset mem_WD", mem_WD, 32'h0);
    rst_n = 1'b1;

    // Fill memory through the unit so bench memory and reference agree
    for (int i = 0; i < 64; i++) run(1'b1, 3'b010, 32'(i * 4), 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000);

    // Test 1
    run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("T1 SW latency", 32'(last_lat), 32'd2);
    chk("T1 SW address", last_wa, 32'h10);
    w0 = we_cnt;
    run(1'b0, 3'b010, 32'h10, 32'h0);
    chk("T1 LW rdata", last_rdata, 32'hDEADBEEF);
    chk("T1 LW latency", 32'(last_lat), 32'd2);
    chk("T1 LW no write", 32'(we_cnt - w0), 32'd0);

    // Test 2
    run(1'b1, 3'b010, 32'h08, 32'h11223344);
    run(1'b1, 3'b000, 32'h0A, 32'h000000AA);
    chk("T2 SB latency", 32'(last_lat), 32'd3);
    run(1'b0, 3'b010, 32'h08, 32'h0);
    chk("T2 merged word", last_rdata, 32'h11AA3344);
    run(1'b0, 3'b000, 32'h0A, 32'h0);
    chk("T2 LB", last_rdata, 32'hFFFFFFAA);
    run(1'b0, 3'b100, 32'h0A, 32'h0);
    chk("T2 LBU", last_rdata, 32'h000000AA);

    // Test 3
    run(1'b1, 3'b010, 32'h04, 32'h80017FFF);
    run(1'b0, 3'b001, 32'h06, 32'h0);
    chk("T3 LH 6", last_rdata, 32'hFFFF8001);
    run(1'b0, 3'b101, 32'h06, 32'h0);
    chk("T3 LHU 6", last_rdata, 32'h00008001);
    run(1'b0, 3'b001, 32'h04, 32'h0);
    chk("T3 LH 4", last_rdata, 32'h00007FFF);
    run(1'b1, 3'b001, 32'h06, 32'h0000CAFE);
    run(1'b0, 3'b010, 32'h04, 32'h0);
    chk("T3 SH upper merge", last_rdata, 32'hCAFE7FFF);

    // Test 4: rejected accesses
    w0 = we_cnt;
    run(1'b0, 3'b010, 32'h02, 32'h0);
    chk("T4 LW 0x2 err", {31'b0, last_err}, 32'd1);
    chk("T4 LW 0x2 latency", 32'(last_lat), 32'd1);
    run(1'b1, 3'b001, 32'h05, 32'h1234);
    chk("T4 SH 0x5 err", {31'b0, last_err}, 32'd1);
    run(1'b0, 3'b010, 32'h100, 32'h0);
    chk("T4 LW 0x100 err", {31'b0, last_err}, 32'd1);
    chk("T4 LW 0x100 rdata", last_rdata, 32'h0);
    run(1'b0, 3'b011, 32'h00, 32'h0);
    chk("T4 funct3 011 err", {31'b0, last_err}, 32'd1);
    run(1'b1, 3'b011, 32'h00, 32'h0);
    chk("T4 store funct3 011 latency", 32'(last_lat), 32'd1);
    chk("T4 no writes", 32'(we_cnt - w0), 32'd0);

    // Test 5: reset during the write phase of an SB
    run(1'b1, 3'b010, 32'h20, 32'h55667788);
    chk_en = 1'b0;
    issue(1'b1, 3'b000, 32'h21, 32'h99, 1'b0);
    t = 0;
    while (!mem_WE && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!mem_WE) fail_now("T5 write phase not reached");
    rst_n = 1'b0;
    #1;
    chk("T5 mem_WE drops", {31'b0, mem_WE}, 32'd0);
    chk("T5 no resp", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("T5 word unchanged", mem[8], 32'h55667788);
    chk("T5 req_ready", {31'b0, req_ready}, 32'd1);
    chk("T5 resp_rdata", resp_rdata, 32'h0);
    chk("T5 mem_A", mem_A, 32'h0);
    chk("T5 mem_WD", mem_WD, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("T5 no resp after", {31'b0, resp_valid}, 32'd0);
    chk_en = 1'b1;

    // Test 6: random back-to-back traffic, valid held while busy
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_ok[$urandom_range(0, 4)];
      idx = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(64, 90)) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) off = 32'($urandom_range(0, 3));
      else if (f3[1:0] == 2'd0) off = 32'($urandom_range(0, 3));
      else if (f3[1:0] == 2'd1) off = 32'($urandom_range(0, 1)) * 2;
      else off = 32'd0;
      a = (idx << 2) | off;
      issue(we, f3, a, $urandom(), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        #1 req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    #1 req_valid = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    to = (exp_q.size() != 0 || wr_q.size() != 0);
    if (to) fail_now("drain timeout");
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
